// File: rtl/receptor_transacciones_i2c.sv
// receptor_transacciones_i2c: I2C target clocked by clk; decodes START/STOP, ACKs its own
// address, captures written words and serializes read words back to the generator.
module receptor_transacciones_i2c #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCL,
    input  logic              SDA_OE,
    input  logic              SDA_OUT,
    input  logic [ADDR_W-1:0] I2C_ADDR,
    input  logic [DATA_W-1:0] RD_DATA,
    output logic              SDA_IN,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              WR_VALID,
    output logic              RD_REQ,
    output logic              BUSY
);
    localparam int CW = $clog2(DATA_W);
    typedef enum logic [2:0] {IDLE, ADDR, ACK_A, WR, ACK_W, RD, ACK_R, WAIT_STOP} state_t;
    state_t            state_q;
    logic              scl_q, sda_q, rnw_q, ph_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-2:0] rx_q;
    logic [DATA_W-1:0] tx_q;
    logic              sda, scl_rise, scl_fall, start, stop;
    assign sda      = SDA_OE ? SDA_OUT : SDA_IN;
    assign scl_rise = SCL & ~scl_q;
    assign scl_fall = ~SCL & scl_q;
    assign start    = scl_q & SCL & sda_q & ~sda;
    assign stop     = scl_q & SCL & ~sda_q & sda;
    assign BUSY     = state_q != IDLE;
    // ph_q marks the second half of an ACK slot (ACK_A/ACK_W driving, ACK_R reload pending)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            rnw_q    <= 1'b0;
            ph_q     <= 1'b0;
            cnt_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            SDA_IN   <= 1'b1;
            WR_DATA  <= '0;
            WR_VALID <= 1'b0;
            RD_REQ   <= 1'b0;
        end else begin
            scl_q    <= SCL;
            sda_q    <= sda;
            WR_VALID <= 1'b0;
            RD_REQ   <= 1'b0;
            if (stop) begin
                state_q <= IDLE;
                SDA_IN  <= 1'b1;
                cnt_q   <= '0;
                ph_q    <= 1'b0;
            end else if (start) begin
                state_q <= ADDR;
                SDA_IN  <= 1'b1;
                cnt_q   <= '0;
                ph_q    <= 1'b0;
            end else begin
                case (state_q)
                    ADDR: if (scl_rise) begin
                        rx_q  <= {rx_q[DATA_W-3:0], sda};
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(ADDR_W)) begin
                            cnt_q   <= '0;
                            rnw_q   <= sda;
                            ph_q    <= 1'b0;
                            state_q <= (rx_q[ADDR_W-1:0] == I2C_ADDR) ? ACK_A : WAIT_STOP;
                        end
                    end
                    ACK_A, ACK_W: if (scl_fall) begin
                        ph_q  <= ~ph_q;
                        cnt_q <= '0;
                        if (!ph_q) begin
                            SDA_IN <= 1'b0;
                        end else if (state_q == ACK_A && rnw_q) begin
                            state_q <= RD;
                            RD_REQ  <= 1'b1;
                            tx_q    <= RD_DATA;
                            SDA_IN  <= RD_DATA[DATA_W-1];
                        end else begin
                            state_q <= WR;
                            SDA_IN  <= 1'b1;
                        end
                    end
                    WR: if (scl_rise) begin
                        rx_q  <= {rx_q[DATA_W-3:0], sda};
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(DATA_W - 1)) begin
                            WR_DATA  <= {rx_q, sda};
                            WR_VALID <= 1'b1;
                            ph_q     <= 1'b0;
                            state_q  <= ACK_W;
                        end
                    end
                    RD: if (scl_fall) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(DATA_W - 1)) begin
                            SDA_IN  <= 1'b1;
                            ph_q    <= 1'b0;
                            state_q <= ACK_R;
                        end else begin
                            SDA_IN <= tx_q[DATA_W-2];
                            tx_q   <= tx_q << 1;
                        end
                    end
                    ACK_R: begin
                        if (scl_rise && !ph_q) begin
                            if (!sda) begin
                                RD_REQ <= 1'b1;
                                tx_q   <= RD_DATA;
                                ph_q   <= 1'b1;
                            end else begin
                                state_q <= WAIT_STOP;
                            end
                        end else if (scl_fall && ph_q) begin
                            state_q <= RD;
                            SDA_IN  <= tx_q[DATA_W-1];
                            cnt_q   <= '0;
                            ph_q    <= 1'b0;
                        end
                    end
                    default: SDA_IN <= 1'b1;
                endcase
            end
        end
    end
endmodule
